// File: rtl/period_meter.sv
// Measures period and high time of an asynchronous toggling input in clk cycles, with a sticky timeout.
// Define PERIOD_METER_FILTER_EN to insert a FILTER_CYCLES-long glitch filter after the synchronizer.
module period_meter #(
   parameter int WIDTH          = 32,
   parameter int TIMEOUT_CYCLES = 150_000_000,
   parameter int FILTER_CYCLES  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sig_in,
   output logic             level,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] high_time,
   output logic             valid,
   output logic             timeout
);

   typedef enum logic {IDLE, MEASURE} state_t;

   logic             sync1_reg, sync2_reg, level_d_reg;
   logic             level_int, rise, fall;
   logic [WIDTH-1:0] cnt_reg, hi_cnt_reg;
   state_t           state_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_reg   <= 1'b0;
         sync2_reg   <= 1'b0;
         level_d_reg <= 1'b0;
      end else begin
         sync1_reg   <= sig_in;
         sync2_reg   <= sync1_reg;
         level_d_reg <= level_int;
      end
   end

`ifdef PERIOD_METER_FILTER_EN
   localparam int FW = $clog2(FILTER_CYCLES + 1);

   logic [FW-1:0] flt_cnt_reg;
   logic          flt_level_reg;

   // level follows the synced input only once it has differed for FILTER_CYCLES cycles in a row
   always_ff @(posedge clk) begin
      if (reset) begin
         flt_cnt_reg   <= '0;
         flt_level_reg <= 1'b0;
      end else if (sync2_reg != flt_level_reg) begin
         if (flt_cnt_reg == FW'(FILTER_CYCLES - 1)) begin
            flt_level_reg <= sync2_reg;
            flt_cnt_reg   <= '0;
         end else begin
            flt_cnt_reg <= flt_cnt_reg + FW'(1);
         end
      end else begin
         flt_cnt_reg <= '0;
      end
   end

   assign level_int = flt_level_reg;
`else
   assign level_int = sync2_reg;
`endif

   assign level = level_int;
   assign rise  = level_int & ~level_d_reg;
   assign fall  = ~level_int & level_d_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         hi_cnt_reg <= '0;
         period     <= '0;
         high_time  <= '0;
         valid      <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state_reg)
            IDLE: begin
               // a first edge only arms the measurement
               if (rise) begin
                  cnt_reg    <= '0;
                  hi_cnt_reg <= '0;
                  state_reg  <= MEASURE;
               end
            end
            MEASURE: begin
               // a rise in the timeout cycle still counts as a measurement
               if (rise) begin
                  period    <= cnt_reg + WIDTH'(1);
                  high_time <= hi_cnt_reg;
                  valid     <= 1'b1;
                  timeout   <= 1'b0;
                  cnt_reg   <= '0;
               end else if (cnt_reg == WIDTH'(TIMEOUT_CYCLES - 1)) begin
                  timeout   <= 1'b1;
                  state_reg <= IDLE;
               end else begin
                  cnt_reg <= cnt_reg + WIDTH'(1);
                  if (fall) begin
                     hi_cnt_reg <= cnt_reg + WIDTH'(1);
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: expected measurements come from the high/low segment lengths driven.
module tb_period_meter;

   localparam int TO = 100;
   localparam int FC = 4;
`ifdef PERIOD_METER_FILTER_EN
   localparam int LAT    = 3 + FC;
   localparam int MINSEG = FC;
`else
   localparam int LAT    = 3;
   localparam int MINSEG = 1;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        sig_in;
   logic        level;
   logic [31:0] period;
   logic [31:0] high_time;
   logic        valid;
   logic        timeout;

   period_meter #(
      .WIDTH          (32),
      .TIMEOUT_CYCLES (TO),
      .FILTER_CYCLES  (FC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .sig_in    (sig_in),
      .level     (level),
      .period    (period),
      .high_time (high_time),
      .valid     (valid),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int p;
      int h;
   } exp_t;

   exp_t sbq[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // reference model: one entry per cycle of the input, measured from its rise
   bit armed;
   int last_high;
   int last_total;

   task automatic check(input string name, input longint act, input longint req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   task automatic model_rise();
      exp_t e;
      if (armed && last_total <= TO) begin
         e.p = last_total;
         e.h = last_high;
         sbq.push_back(e);
      end
      armed = 1'b1;
   endtask

   task automatic drive(input bit v, input int n);
      sig_in = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_cycle(input int h, input int l);
      model_rise();
      last_high  = h;
      last_total = h + l;
      drive(1'b1, h);
      drive(1'b0, l);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_period"}, period, 0);
      check({tag, "_high_time"}, high_time, 0);
      check({tag, "_valid"}, valid, 0);
      check({tag, "_timeout"}, timeout, 0);
      check({tag, "_level"}, level, 0);
   endtask

   task automatic do_reset();
      drive(1'b0, LAT + 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_zero_outputs("midreset");
      check("midreset_pending", sbq.size(), 0);
      reset = 1'b0;
      armed = 1'b0;
   endtask

   task automatic glitch_cycle();
`ifdef PERIOD_METER_FILTER_EN
      model_rise();
      last_high  = 10;
      last_total = 20;
      drive(1'b1, 10);
      drive(1'b0, 4);
      drive(1'b1, 2);
      drive(1'b0, 4);
`else
      send_cycle(10, 4);
      send_cycle(2, 4);
`endif
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: stopped at cycle %0d, expected completion well before", cyc);
      $fatal(1);
   end

   initial begin
      int rc;
      reset      = 1'b1;
      sig_in     = 1'b0;
      armed      = 1'b0;
      last_high  = 0;
      last_total = 0;

      fork
         begin : monitor
            exp_t e;
            forever begin
               @(negedge clk);
               if (valid) begin
                  if (sbq.size() == 0) begin
                     check("unexpected_valid", 1, 0);
                  end else begin
                     e = sbq.pop_front();
                     check("period", period, e.p);
                     check("high_time", high_time, e.h);
                     check("timeout_on_valid", timeout, 0);
                  end
               end
            end
         end
      join_none

      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      reset = 1'b0;
      drive(1'b0, 3);

      // square wave 10/5
      repeat (6) send_cycle(5, 5);

`ifndef PERIOD_METER_FILTER_EN
      // narrow pulse train, then the minimum period
      repeat (4) send_cycle(1, 6);
      repeat (4) send_cycle(1, 1);
`endif

      // stop toggling after a valid; timeout timing and held outputs
      send_cycle(7, 3);
      send_cycle(7, 3);
      model_rise();
      rc         = cyc;
      last_high  = 5;
      last_total = 100_000;
      drive(1'b1, 5);
      sig_in = 1'b0;
      while (cyc < rc + LAT + TO - 1) begin
         @(posedge clk);
         #1;
      end
      check("timeout_early", timeout, 0);
      @(posedge clk);
      #1;
      check("timeout_set", timeout, 1);
      check("timeout_period_held", period, 10);
      check("timeout_high_held", high_time, 7);
      send_cycle(6, 4);
      check("timeout_sticky", timeout, 1);
      send_cycle(6, 4);
      send_cycle(6, 4);
      check("timeout_cleared", timeout, 0);

      // boundary: exactly TO is measured, TO+1 times out
      send_cycle(50, 50);
      send_cycle(50, 51);
      send_cycle(MINSEG + 2, MINSEG + 2);
      send_cycle(MINSEG + 2, MINSEG + 2);

      // reset mid-period
      send_cycle(6, 6);
      do_reset();
      send_cycle(8, 4);
      send_cycle(8, 4);
      send_cycle(8, 4);

      // 20-cycle wave with a 2-cycle glitch in the low phase
      glitch_cycle();
      glitch_cycle();
      send_cycle(10, 10);

      // randomized segments
      repeat (40) send_cycle($urandom_range(12, MINSEG), $urandom_range(12, MINSEG));

      drive(1'b0, LAT + 4);
      check("queue_drained", sbq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
